// File: rtl/line_mem_responder_if.sv
// Cache-line request/acknowledge bus between the data cache and the memory responder.
// Signal names keep the memory side's i/o sense: *_i flow into the responder.
interface line_mem_if;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         err_o;
  logic         busy_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, err_o, busy_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, err_o, busy_o
  );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency 256-bit line memory: latches one request, waits LATENCY edges,
// commits/fetches the line, then pulses ack. Saturating read/write counters.
module line_mem_responder #(
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9,
  parameter int LATENCY = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  line_mem_if.slave        bus,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [7:0]       LAT     = 8'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [255:0] mem [DEPTH];

  state_t       r_state, w_next;
  logic [7:0]   r_cnt;
  logic [31:0]  r_addr;
  logic         r_write;
  logic [255:0] r_data;
  logic [255:0] r_rdata;
  logic [CNT_W-1:0] r_rd_cnt, r_wr_cnt;

  logic             w_enter_ack;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;

  // Any nonzero bit above the index field also lands out of range here.
  assign w_in_range  = ({5'd0, r_addr[31:5]} < 32'(DEPTH));
  assign w_idx       = r_addr[5 +: IDX_W];
  assign w_enter_ack = (r_state == S_WAIT) && (r_cnt == LAT);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.enable_i) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == LAT) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE && bus.enable_i) begin
      r_cnt   <= 8'd1;
      r_addr  <= bus.addr_i;
      r_write <= bus.write_i;
      r_data  <= bus.data_i;
    end else if (r_state == S_WAIT && r_cnt != LAT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Commit lands on the ACK-entry edge, so any later read sees it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_enter_ack && r_write && w_in_range)
      mem[w_idx] <= r_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_rdata <= '0;
    else if (w_enter_ack && !r_write && w_in_range)
      r_rdata <= mem[w_idx];
    else
      r_rdata <= '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_enter_ack && w_in_range) begin
      if (!r_write && r_rd_cnt != CNT_MAX) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (r_write && r_wr_cnt != CNT_MAX)  r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  assign bus.ack_o  = (r_state == S_ACK);
  assign bus.err_o  = (r_state == S_ACK) && !w_in_range;
  assign bus.busy_o = (r_state != S_IDLE);
  assign bus.data_o = r_rdata;
  assign rd_cnt_o   = r_rd_cnt;
  assign wr_cnt_o   = r_wr_cnt;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: latency, read/write, range errors,
// reset abort, input isolation during WAIT and counter saturation.
module tb_line_mem_responder;
  localparam int DEPTH   = 512;
  localparam int IDX_W   = 9;
  localparam int LATENCY = 10;
  localparam int CNT_W   = 16;

  localparam logic [255:0] P0   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] OLD1 = {8{32'h0101_A5A5}};
  localparam logic [255:0] OLD3 = {8{32'h0303_5A5A}};
  localparam logic [255:0] P511 = {8{32'h0511_C3C3}};
  localparam logic [255:0] ECFA = {16{16'hECFA}};
  localparam logic [255:0] D2   = {8{32'h2222_1357}};

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  line_mem_if bus();

  line_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus.slave),
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; returns acceptance cycle and the ack-cycle data/err.
  task automatic req(input logic wr, input logic [31:0] a, input logic [255:0] d,
                     input bit keep, input bit garble,
                     output int acc, output logic [255:0] rdat, output logic rerr);
    int n;
    @(posedge clk); #1;
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = a;
    bus.data_i   = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.busy_o && n < 20);
    chk("accept", 256'(bus.busy_o), 256'(1));
    acc = cyc;
    if (garble) begin
      bus.addr_i   = 32'h0000_0060;
      bus.data_i   = {8{32'hDEAD_BEEF}};
      bus.enable_i = 1'b0;
    end
    n = 0;
    while (!bus.ack_o && n < 300) begin @(posedge clk); #1; n++; end
    chk("latency", 256'(n), 256'(LATENCY));
    rdat = bus.data_o;
    rerr = bus.err_o;
    if (!keep) begin
      bus.enable_i = 1'b0;
      @(posedge clk); #1;
      chk("ack_one_cycle", 256'(bus.ack_o), 256'(0));
    end
  endtask

  initial begin
    int a1, a2;
    logic [255:0] rd;
    logic er;
    bit saw_ack;

    rst = 1'b1;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    dut.mem[0]   = P0;
    dut.mem[1]   = OLD1;
    dut.mem[3]   = OLD3;
    dut.mem[511] = P511;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ack", 256'(bus.ack_o), 256'(0));
    chk("rst_err", 256'(bus.err_o), 256'(0));
    chk("rst_data", bus.data_o, 256'(0));
    chk("rst_busy", 256'(bus.busy_o), 256'(0));
    chk("rst_rdcnt", 256'(rd_cnt), 256'(0));
    chk("rst_wrcnt", 256'(wr_cnt), 256'(0));

    // Preloaded read of line 0
    req(1'b0, 32'h0000_0000, '0, 1'b0, 1'b0, a1, rd, er);
    chk("rd0_data", rd, P0);
    chk("rd0_err", 256'(er), 256'(0));
    chk("rd0_rdcnt", 256'(rd_cnt), 256'(1));
    chk("rd0_data_after", bus.data_o, 256'(0));

    // Write line 16 then immediately read it back with enable held
    req(1'b1, 32'h0000_0200, ECFA, 1'b1, 1'b0, a1, rd, er);
    chk("wr16_data_o", rd, 256'(0));
    req(1'b0, 32'h0000_0200, '0, 1'b0, 1'b0, a2, rd, er);
    chk("raw16_data", rd, ECFA);
    chk("raw16_mem", dut.mem[16], ECFA);
    chk("raw16_spacing", 256'(a2 - a1), 256'(12));
    chk("raw16_wrcnt", 256'(wr_cnt), 256'(1));
    chk("raw16_rdcnt", 256'(rd_cnt), 256'(2));

    // Out-of-range read (line 512) and write (top of address space)
    req(1'b0, 32'h0000_4000, '0, 1'b0, 1'b0, a1, rd, er);
    chk("oor_rd_err", 256'(er), 256'(1));
    chk("oor_rd_data", rd, 256'(0));
    req(1'b1, 32'hFFFF_FFE0, {8{32'hBAD0_BAD0}}, 1'b0, 1'b0, a1, rd, er);
    chk("oor_wr_err", 256'(er), 256'(1));
    chk("oor_wr_data", rd, 256'(0));
    chk("oor_mem511", dut.mem[511], P511);
    chk("oor_mem0", dut.mem[0], P0);
    chk("oor_rdcnt", 256'(rd_cnt), 256'(2));
    chk("oor_wrcnt", 256'(wr_cnt), 256'(1));

    // Reset in the middle of a write to line 1 aborts it
    @(posedge clk); #1;
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0020;
    bus.data_i   = {8{32'hFACE_0001}};
    @(posedge clk); #1;
    chk("abort_accept", 256'(bus.busy_o), 256'(1));
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.enable_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) saw_ack = 1'b1;
    end
    chk("abort_no_ack", 256'(saw_ack), 256'(0));
    chk("abort_idle", 256'(bus.busy_o), 256'(0));
    chk("abort_mem1", dut.mem[1], OLD1);
    chk("abort_rdcnt", 256'(rd_cnt), 256'(0));
    chk("abort_wrcnt", 256'(wr_cnt), 256'(0));
    req(1'b0, 32'h0000_0020, '0, 1'b0, 1'b0, a1, rd, er);
    chk("abort_rd1", rd, OLD1);
    chk("abort_rd1_cnt", 256'(rd_cnt), 256'(1));

    // Inputs garbled and enable dropped during WAIT of a write to line 2
    req(1'b1, 32'h0000_0040, D2, 1'b0, 1'b1, a1, rd, er);
    chk("garble_err", 256'(er), 256'(0));
    chk("garble_mem2", dut.mem[2], D2);
    chk("garble_mem3", dut.mem[3], OLD3);
    chk("garble_wrcnt", 256'(wr_cnt), 256'(1));

    // Saturation of the write counter
    @(posedge clk); #1;
    dut.r_wr_cnt = 16'hFFFE;
    req(1'b1, 32'h0000_0080, {8{32'h4444_0001}}, 1'b0, 1'b0, a1, rd, er);
    chk("sat_wrcnt_1", 256'(wr_cnt), 256'(16'hFFFF));
    req(1'b1, 32'h0000_0080, {8{32'h4444_0002}}, 1'b0, 1'b0, a1, rd, er);
    req(1'b1, 32'h0000_0080, {8{32'h4444_0003}}, 1'b0, 1'b0, a1, rd, er);
    chk("sat_wrcnt_3", 256'(wr_cnt), 256'(16'hFFFF));
    chk("sat_mem4", dut.mem[4], {8{32'h4444_0003}});
    chk("sat_rdcnt", 256'(rd_cnt), 256'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
